// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if -- bus between the Morse symbol decoder, the scan
// controller and the board pins.
//   char_valid  decoder -> ctrl   one-cycle pulse, char_code is new
//   char_code   decoder -> ctrl   4-bit code, 0-9 digits, 10-15 blank
//   clear       decoder -> ctrl   one-cycle pulse, empty the buffer
//   seg_out     ctrl -> pins      active-low segments, bit7 = DP (always 1)
//   an_out      ctrl -> pins      active-low digit enables, one-hot-zero
//   count       ctrl -> decoder   valid characters held, saturates at DIGITS
// DIGITS must match the DIGITS of the attached display_scan_ctrl.
interface display_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic              char_valid;
    logic [3:0]        char_code;
    logic              clear;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] an_out;
    logic [3:0]        count;

    modport master (
        output char_valid, char_code, clear,
        input  seg_out, an_out, count
    );

    modport slave (
        input  char_valid, char_code, clear,
        output seg_out, an_out, count
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl -- multiplexed 7-segment controller for decoded Morse
// characters. Holds the last DIGITS characters in a shift buffer and scans
// them onto a shared active-low segment bus; every digit slot opens with a
// blanking interval to suppress ghosting.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  display_scan_ctrl_if.slave (char_valid, char_code, clear in;
//        seg_out, an_out, count out)
module display_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_TH = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [3:0]    FULL     = 4'(DIGITS);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [3:0]        entry [DIGITS];
    logic [3:0]        count_q;
    logic [7:0]        seg_q;
    logic [DIGITS-1:0] an_q;
    phase_t            phase;
    logic [3:0]        sel;

    function automatic logic [7:0] encode(input logic [3:0] c);
        logic [7:0] s;
        case (c)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        phase = (cnt < BLANK_TH) ? PH_BLANK : PH_SHOW;
        sel   = entry[idx];
    end

    // Character buffer: clear has priority over a simultaneous push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DIGITS; i++) entry[i] <= 4'hF;
            count_q <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < DIGITS; i++) entry[i] <= 4'hF;
            count_q <= '0;
        end else if (bus.char_valid) begin
            for (int unsigned i = 1; i < DIGITS; i++) entry[i] <= entry[i-1];
            entry[0] <= bus.char_code;
            if (count_q != FULL) count_q <= count_q + 4'd1;
        end
    end

    // Free-running scan; pin registers are loaded from the current (cnt, idx)
    // so the pins lag the sequencer by exactly one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            seg_q <= '1;
            an_q  <= '1;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (phase == PH_BLANK) begin
                seg_q <= '1;
                an_q  <= '1;
            end else begin
                seg_q <= encode(sel);
                an_q  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
            end
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.an_out  = an_q;
    assign bus.count   = count_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl -- directed bench for display_scan_ctrl with
// DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2. A table of buffer operations with
// hand-computed count and per-digit segment patterns, plus hand-written
// sequences for the post-reset scan timing and an asynchronous mid-slot reset.
module tb_display_scan_ctrl;

    logic clk;
    logic rst;

    display_scan_ctrl_if #(.DIGITS(4)) bus ();

    display_scan_ctrl #(
        .DIGITS      (4),
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            cv;
        logic [3:0]      code;
        logic            clr;
        logic [3:0]      exp_count;
        logic [3:0][7:0] exp_seg;   // [k] = pattern shown under anode k
    } vec_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    vec_t        vecs [14];

    function automatic vec_t mk(input logic cv, input logic [3:0] code,
                                input logic clr, input logic [3:0] c,
                                input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] s2, input logic [7:0] s3);
        vec_t v;
        v.cv        = cv;
        v.code      = code;
        v.clr       = clr;
        v.exp_count = c;
        v.exp_seg   = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Watch one full scan period; record the pattern shown under each anode
    // and flag any illegal anode shape or unsteady segment within a slot.
    task automatic observe_frame(input int v, input logic [3:0][7:0] exp);
        logic [7:0] seen [4];
        bit         shape_ok;
        int         nlow;
        int         lowpos;
        for (int k = 0; k < 4; k++) seen[k] = 8'h00;
        shape_ok = 1'b1;
        repeat (32) begin
            @(negedge clk);
            nlow   = 0;
            lowpos = 0;
            for (int k = 0; k < 4; k++) begin
                if (bus.an_out[k] !== 1'b1) begin
                    nlow++;
                    lowpos = k;
                end
            end
            if (nlow == 0) begin
                if (bus.seg_out !== 8'hFF) shape_ok = 1'b0;
            end else if (nlow > 1 || bus.an_out[lowpos] !== 1'b0) begin
                shape_ok = 1'b0;
            end else if (seen[lowpos] == 8'h00) begin
                seen[lowpos] = bus.seg_out;
            end else if (seen[lowpos] !== bus.seg_out) begin
                shape_ok = 1'b0;
            end
        end
        chk($sformatf("v%0d an_shape", v), {7'd0, shape_ok}, 8'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("v%0d seg_idx%0d", v, k), seen[k], exp[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_an;
        bit         found;

        vecs[0]  = mk(0, 4'h0, 0, 4'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[1]  = mk(1, 4'h3, 0, 4'd1, 8'hB0, 8'hFF, 8'hFF, 8'hFF);
        vecs[2]  = mk(0, 4'h0, 1, 4'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[3]  = mk(1, 4'h1, 0, 4'd1, 8'hF9, 8'hFF, 8'hFF, 8'hFF);
        vecs[4]  = mk(1, 4'h2, 0, 4'd2, 8'hA4, 8'hF9, 8'hFF, 8'hFF);
        vecs[5]  = mk(1, 4'h3, 0, 4'd3, 8'hB0, 8'hA4, 8'hF9, 8'hFF);
        vecs[6]  = mk(1, 4'h4, 0, 4'd4, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        vecs[7]  = mk(1, 4'h5, 0, 4'd4, 8'h92, 8'h99, 8'hB0, 8'hA4);
        vecs[8]  = mk(0, 4'h0, 1, 4'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[9]  = mk(1, 4'h7, 0, 4'd1, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
        vecs[10] = mk(1, 4'h8, 0, 4'd2, 8'h80, 8'hF8, 8'hFF, 8'hFF);
        vecs[11] = mk(1, 4'h9, 1, 4'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[12] = mk(1, 4'hA, 0, 4'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        vecs[13] = mk(1, 4'h0, 0, 4'd2, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Reset and idle scan timing.
        rst            = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_code  = 4'h0;
        bus.clear      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst an_out", {4'h0, bus.an_out}, 8'h0F);
        chk("rst seg_out", bus.seg_out, 8'hFF);
        chk("rst count", {4'h0, bus.count}, 8'h00);
        rst = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            exp_an = ((t % 8) < 2) ? 4'b1111 : ~(4'b0001 << ((t / 8) % 4));
            chk($sformatf("idle t%0d an_out", t), {4'h0, bus.an_out}, {4'h0, exp_an});
            chk($sformatf("idle t%0d seg_out", t), bus.seg_out, 8'hFF);
        end
        chk("idle count", {4'h0, bus.count}, 8'h00);

        // Table-driven buffer operations.
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            bus.char_valid = vecs[v].cv;
            bus.char_code  = vecs[v].code;
            bus.clear      = vecs[v].clr;
            @(negedge clk);
            bus.char_valid = 1'b0;
            bus.char_code  = 4'h0;
            bus.clear      = 1'b0;
            chk($sformatf("v%0d count", v), {4'h0, bus.count}, {4'h0, vecs[v].exp_count});
            observe_frame(v, vecs[v].exp_seg);
        end

        // Asynchronous reset while idx 1 is shown: buffer becomes 6,0,A,F.
        @(negedge clk);
        bus.char_valid = 1'b1;
        bus.char_code  = 4'h6;
        @(negedge clk);
        bus.char_valid = 1'b0;
        bus.char_code  = 4'h0;
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (bus.an_out === 4'b1101) found = 1'b1;
        end
        chk("arst found_1101", {7'd0, found}, 8'd1);
        if (found) begin
            chk("arst pre seg_out", bus.seg_out, 8'hC0);
            #1 rst = 1'b0;
            #1;
            chk("arst an_out", {4'h0, bus.an_out}, 8'h0F);
            chk("arst seg_out", bus.seg_out, 8'hFF);
            chk("arst count", {4'h0, bus.count}, 8'h00);
            repeat (2) @(negedge clk);
            chk("arst held an_out", {4'h0, bus.an_out}, 8'h0F);
            rst = 1'b1;
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                exp_an = (t < 2) ? 4'b1111 : 4'b1110;
                chk($sformatf("arst rel t%0d an_out", t), {4'h0, bus.an_out}, {4'h0, exp_an});
                chk($sformatf("arst rel t%0d seg_out", t), bus.seg_out, 8'hFF);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Multiplexed 7-segment display controller for the Morse decoder output.
- Keeps a shift buffer of the last DIGITS decoded characters and time-multiplexes them onto one shared active-low segment bus.
- Each digit slot starts with a blanking interval to suppress ghosting.
- Sits between the symbol decoder (char_valid/char_code) and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of digit positions scanned (2..8)
SCAN_DIV, 100000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (1 <= BLANK_CYCLES < SCAN_DIV)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
char_valid  in  1  one-cycle pulse: char_code holds a newly decoded character
char_code  in  4  character code; 0-9 are digits, 10-15 display blank
clear  in  1  one-cycle pulse: empty the buffer
seg_out  out  8  segment pattern, active-low, bit7 = DP (always 1)
an_out  out  DIGITS  digit enables, active-low, one-hot-zero
count  out  4  number of valid characters in the buffer, saturating at DIGITS

Behaviour:
- Reset (rst=0, asynchronous):
  - all buffer entries = 4'hF (blank); count = 0
  - slot counter cnt = 0; digit index idx = 0
  - seg_out = 8'hFF; an_out = all ones
- Buffer update (synchronous, after reset release):
  - clear=1: all entries <= 4'hF, count <= 0. Clear wins over a char_valid in the same cycle.
  - char_valid=1 and clear=0: entry[i] <= entry[i-1] for i=DIGITS-1..1; entry[0] <= char_code. The oldest entry is dropped. count <= min(count+1, DIGITS).
  - Otherwise the buffer and count hold.
  - New data is visible in the buffer one cycle after the pulse. It reaches the pins when idx next selects that entry.
- Scan sequencer:
  - cnt runs 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx <= idx+1, wrapping DIGITS-1 -> 0.
  - Scanning is free-running and is never stalled by buffer updates.
- Slot phases:
  - BLANK (cnt < BLANK_CYCLES): an_out = all ones, seg_out = 8'hFF.
  - SHOW (cnt >= BLANK_CYCLES): an_out bit idx = 0, all other bits = 1; seg_out = encode(entry[idx]).
- Output timing:
  - seg_out and an_out are registered and reflect the (cnt, idx) of the previous cycle. Latency is 1 clock.
  - Outputs are glitch-free; an_out never has more than one bit low.
- encode() mapping: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, 10..15->FF (hex).
- Segment changes only at slot boundaries. The mid-slot rule is fixed here: if the selected entry changes during SHOW, seg_out follows on the next clock. This is allowed because the entry stays under the same anode.
- Reset asserted mid-slot: outputs go to the reset values immediately, without waiting for a clock. After release the scan restarts at idx 0, cnt 0 with a BLANK phase.
- count drives no display logic. Blank positions come from the 4'hF contents of the buffer.

Test Plan:
- Reset/idle: DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2. Hold rst=0, then release; run 40 cycles.
  -> seg_out = FF throughout; an_out cycles through BLANK (1111) and SHOW (1110, 1101, 1011, 0111), each SHOW lasting 6 cycles; count = 0.
- Single push: char_valid with char_code = 3.
  -> count = 1; during the SHOW of idx 0, an_out = 1110 and seg_out = B0; all other digits show FF.
- Overflow: push 1, 2, 3, 4, 5.
  -> count saturates at 4; entry0..3 = 5, 4, 3, 2; the digit 1 pattern F9 never appears; idx 3 shows A4.
- Clear vs push in the same cycle: after loading 7, 8, assert clear=1 and char_valid=1 (code 9) together.
  -> count = 0; every slot shows FF; the pattern 90 is never output.
- Non-digit code: push 4'hA, then 4'h0.
  -> idx 1 shows FF; idx 0 shows C0; count = 2.
- Asynchronous reset mid-SHOW: while an_out = 1101, drive rst low between clock edges.
  -> an_out = 1111 and seg_out = FF in the same delta, with no clock; after release the first 2 cycles are BLANK, then idx 0 is shown.
